// File: rtl/multisim_quasi_static_pkg.sv
// Shared sizing helpers for the multi-channel quasi-static push client.
package multisim_quasi_static_pkg;

    // Channel id width, at least one bit even for a single channel.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/multisim_quasi_static_chan.sv
// One channel: init snapshot + change detect feeding a bounded FIFO with coalesce/drop on full.
// Head visible one cycle after enqueue; when full and not popping, the newest value overwrites the youngest entry or is dropped.
module multisim_quasi_static_chan
    import multisim_quasi_static_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int QUEUE_DEPTH = 4,
    parameter bit COALESCE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pop,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = cnt_width(QUEUE_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST     = ptr_t'(QUEUE_DEPTH - 1);
    localparam cnt_t FULL_CNT = cnt_t'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] prev;
    logic                  init_pending;
    ptr_t                  rd_ptr, wr_ptr, youngest;
    cnt_t                  count;
    logic                  change, full, do_pop, accept, squash;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A pop frees a slot in the same cycle, so a full FIFO being popped still accepts.
    always_comb begin
        change   = init_pending || (data != prev);
        full     = (count == FULL_CNT);
        do_pop   = pop && (count != '0);
        accept   = change && (!full || do_pop);
        squash   = change && full && !do_pop;
        youngest = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= data;
        end else if (squash && COALESCE) begin
            mem[youngest] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev         <= '0;
            init_pending <= 1'b1;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            prev         <= data;
            init_pending <= 1'b0;
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (accept && !do_pop) begin
                count <= count + 1'b1;
            end else if (!accept && do_pop) begin
                count <= count - 1'b1;
            end
            overflow <= (overflow && !overflow_clr) || squash;
        end
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/multisim_client_quasi_static_push_mc.sv
// Watches NUM_CHANNELS quasi-static buses and drains their change FIFOs round-robin onto one push port.
// Push one cycle after the grant; push_rdy low stalls all pops and the channel FIFOs absorb changes.
module multisim_client_quasi_static_push_mc
    import multisim_quasi_static_pkg::*;
#(
    parameter int  NUM_CHANNELS = 4,
    parameter int  DATA_WIDTH   = 64,
    parameter int  QUEUE_DEPTH  = 4,
    parameter bit  COALESCE     = 1'b1,
    localparam int CH_W         = ch_width(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
    input  logic                               push_rdy,
    output logic                               push_vld,
    output logic [DATA_WIDTH-1:0]              push_data,
    output logic [CH_W-1:0]                    push_channel,
    output logic [NUM_CHANNELS-1:0]            overflow,
    input  logic [NUM_CHANNELS-1:0]            overflow_clr
);
    logic [NUM_CHANNELS-1:0] empty;
    logic [NUM_CHANNELS-1:0] pop;
    logic [DATA_WIDTH-1:0]   head [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   grant_head;
    logic [CH_W-1:0]         rr;
    logic [CH_W-1:0]         grant_ch;
    logic                    grant_vld;

    // Search starts just after the last granted channel, wrapping modulo NUM_CHANNELS.
    always_comb begin
        grant_vld  = 1'b0;
        grant_ch   = '0;
        grant_head = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (!grant_vld && !empty[c] && (c == (int'(rr) + i) % NUM_CHANNELS)) begin
                    grant_vld  = 1'b1;
                    grant_ch   = CH_W'(c);
                    grant_head = head[c];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign pop[c] = push_rdy && grant_vld && (grant_ch == CH_W'(c));

        multisim_quasi_static_chan #(
            .DATA_WIDTH  (DATA_WIDTH),
            .QUEUE_DEPTH (QUEUE_DEPTH),
            .COALESCE    (COALESCE)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .data         (data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop          (pop[c]),
            .empty        (empty[c]),
            .head         (head[c]),
            .overflow     (overflow[c]),
            .overflow_clr (overflow_clr[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_vld     <= 1'b0;
            push_data    <= '0;
            push_channel <= '0;
            rr           <= CH_W'(NUM_CHANNELS - 1);
        end else begin
            push_vld <= push_rdy && grant_vld;
            if (push_rdy && grant_vld) begin
                push_data    <= grant_head;
                push_channel <= grant_ch;
                rr           <= grant_ch;
            end
        end
    end

endmodule

// File: tb/tb_multisim_client_quasi_static_push_mc.sv
// Drives three configurations (depth 4 coalesce, depth 2 coalesce, depth 2 drop) with the same stimulus
// and compares every cycle against a queue-based reference model plus directed push sequences.
module tb_multisim_client_quasi_static_push_mc;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int NI  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH*DW-1:0] data = '0;
    logic              push_rdy = 1'b0;
    logic [NCH-1:0]    overflow_clr = '0;
    logic              vld  [NI];
    logic [DW-1:0]     pdat [NI];
    logic [1:0]        pch  [NI];
    logic [NCH-1:0]    ovf  [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        multisim_client_quasi_static_push_mc #(
            .NUM_CHANNELS (NCH),
            .DATA_WIDTH   (DW),
            .QUEUE_DEPTH  (k == 0 ? 4 : 2),
            .COALESCE     (k == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .data         (data),
            .push_rdy     (push_rdy),
            .push_vld     (vld[k]),
            .push_data    (pdat[k]),
            .push_channel (pch[k]),
            .overflow     (ovf[k]),
            .overflow_clr (overflow_clr)
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0]  mq [NI*NCH][$];
    logic [DW-1:0]  mprev [NCH];
    bit             minit;
    logic [NCH-1:0] movf [NI];
    int             mrr [NI];
    bit             mvld [NI];
    logic [DW-1:0]  mdat [NI];
    int             mch [NI];

    int plog [NI][$];
    int expq [$];

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic bit coal_of(input int k);
        return (k != 2);
    endfunction

    function automatic logic [DW-1:0] ch_of(input int c);
        return data[c*DW +: DW];
    endfunction

    function automatic int ent(input int c, input int v);
        return c * 65536 + v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int c, input int v);
        data[c*DW +: DW] = DW'(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI * NCH; i++) mq[i].delete();
        for (int c = 0; c < NCH; c++) mprev[c] = '0;
        minit = 1'b1;
        for (int k = 0; k < NI; k++) begin
            movf[k] = '0;
            mrr[k]  = NCH - 1;
            mvld[k] = 1'b0;
            mdat[k] = '0;
            mch[k]  = 0;
        end
    endtask

    // One clock edge of the specified behaviour, from the inputs present at that edge.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            int g;
            logic [NCH-1:0] ovf_set;
            g = -1;
            ovf_set = '0;
            if (push_rdy) begin
                for (int i = 1; i <= NCH; i++) begin
                    int c;
                    c = (mrr[k] + i) % NCH;
                    if (g < 0 && mq[k*NCH+c].size() != 0) g = c;
                end
            end
            if (g >= 0) begin
                mvld[k] = 1'b1;
                mdat[k] = mq[k*NCH+g].pop_front();
                mch[k]  = g;
                mrr[k]  = g;
            end else begin
                mvld[k] = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (minit || ch_of(c) != mprev[c]) begin
                    if (mq[k*NCH+c].size() < depth_of(k)) begin
                        mq[k*NCH+c].push_back(ch_of(c));
                    end else begin
                        ovf_set[c] = 1'b1;
                        if (coal_of(k)) begin
                            void'(mq[k*NCH+c].pop_back());
                            mq[k*NCH+c].push_back(ch_of(c));
                        end
                    end
                end
            end
            movf[k] = (movf[k] & ~overflow_clr) | ovf_set;
        end
        for (int c = 0; c < NCH; c++) mprev[c] = ch_of(c);
        minit = 1'b0;
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("push_vld[%0d]", k), 64'(vld[k]), 64'(mvld[k]));
            check($sformatf("push_data[%0d]", k), 64'(pdat[k]), 64'(mdat[k]));
            check($sformatf("push_channel[%0d]", k), 64'(pch[k]), 64'(mch[k]));
            check($sformatf("overflow[%0d]", k), 64'(ovf[k]), 64'(movf[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            model_edge();
            compare_all();
            for (int k = 0; k < NI; k++) begin
                if (vld[k]) plog[k].push_back(ent(int'(pch[k]), int'(pdat[k])));
            end
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < NI; k++) plog[k].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Compares the logged pushes of instance k (optionally one channel only) with expq.
    task automatic check_log(input int k, input int chan, input string tag);
        int got [$];
        foreach (plog[k][i]) begin
            if (chan < 0 || (plog[k][i] / 65536) == chan) got.push_back(plog[k][i]);
        end
        check({tag, "_len"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 64'(got[i]), 64'(expq[i]));
        end
    endtask

    initial begin
        // Snapshot after reset
        for (int c = 0; c < NCH; c++) set_ch(c, c + 1);
        push_rdy = 1'b1;
        #2;
        do_reset();
        clear_logs();
        repeat (8) step();
        expq = '{ent(0, 1), ent(1, 2), ent(2, 3), ent(3, 4)};
        for (int k = 0; k < NI; k++) check_log(k, -1, $sformatf("snapshot%0d", k));

        // Change order within one channel
        push_rdy = 1'b0;
        do_reset();
        clear_logs();
        step();
        set_ch(1, 5); step();
        set_ch(1, 6); step();
        set_ch(1, 7); step();
        push_rdy = 1'b1;
        repeat (20) step();
        expq = '{ent(1, 2), ent(1, 5), ent(1, 6), ent(1, 7)};
        check_log(0, 1, "order");
        check("order_ovf1", 64'(ovf[0][1]), 64'(0));
        overflow_clr = '1; step(); overflow_clr = '0;

        // Coalesce versus drop on a depth-2 FIFO
        push_rdy = 1'b0;
        clear_logs();
        set_ch(2, 10); step();
        set_ch(2, 11); step();
        set_ch(2, 12); step();
        set_ch(2, 13); step();
        check("coal_ovf2", 64'(ovf[1][2]), 64'(1));
        check("drop_ovf2", 64'(ovf[2][2]), 64'(1));
        check("deep_ovf2", 64'(ovf[0][2]), 64'(0));
        push_rdy = 1'b1;
        repeat (8) step();
        expq = '{ent(2, 10), ent(2, 13)};
        check_log(1, -1, "coalesce");
        expq = '{ent(2, 10), ent(2, 11)};
        check_log(2, -1, "drop");
        expq = '{ent(2, 10), ent(2, 11), ent(2, 12), ent(2, 13)};
        check_log(0, -1, "deep");
        repeat (4) step();
        check("drop_no_reenq", 64'(plog[2].size()), 64'(2));
        overflow_clr = 4'b0100; step(); overflow_clr = '0;
        check("coal_ovf2_clr", 64'(ovf[1][2]), 64'(0));

        // Fairness with every channel changing every cycle
        clear_logs();
        repeat (16) begin
            for (int c = 0; c < NCH; c++) set_ch(c, int'(ch_of(c)) ^ int'($urandom_range(1, 65535)));
            step();
        end
        for (int k = 0; k < NI; k++) begin
            check($sformatf("fair_len%0d", k), 64'(plog[k].size()), 64'(15));
            for (int i = 1; i < plog[k].size(); i++) begin
                check($sformatf("fair%0d_%0d", k, i), 64'(plog[k][i] / 65536),
                      64'(((plog[k][i-1] / 65536) + 1) % NCH));
            end
        end
        repeat (12) step();

        // Randomized traffic
        repeat (400) begin
            push_rdy = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) set_ch(c, int'($urandom_range(0, 7)));
            end
            overflow_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            step();
        end
        overflow_clr = '0;

        // Reset in the middle of a drain
        push_rdy = 1'b1;
        repeat (20) step();
        push_rdy = 1'b0;
        set_ch(0, int'(ch_of(0)) + 1); step();
        set_ch(0, int'(ch_of(0)) + 1); step();
        set_ch(0, int'(ch_of(0)) + 1); step();
        push_rdy = 1'b1;
        step();
        check("mid_vld", 64'(vld[0]), 64'(1));
        for (int c = 0; c < NCH; c++) set_ch(c, 10 * (c + 1));
        do_reset();
        clear_logs();
        repeat (10) step();
        expq = '{ent(0, 10), ent(1, 20), ent(2, 30), ent(3, 40)};
        for (int k = 0; k < NI; k++) check_log(k, -1, $sformatf("post_reset%0d", k));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multisim_client_quasi_static_push_mc.md
Name: multisim_client_quasi_static_push_mc

Overview:
- Multi-channel successor of the single-channel quasi-static push client.
- Watches NUM_CHANNELS slowly changing buses and queues each value change in a bounded per-channel FIFO.
- Drains the FIFOs round-robin onto one push handshake, tagged with channel id.
- Sits between design-side configuration/status signals and a multisim_client_push instance in the wrapping client, whose DATA_WIDTH is DATA_WIDTH+CH_W.

Parameters:
- NUM_CHANNELS, 4, number of monitored channels (>=1).
- DATA_WIDTH, 64, bits per channel.
- QUEUE_DEPTH, 4, entries per channel FIFO (>=2).
- COALESCE, 1: on full, overwrite youngest entry with newest value. 0: on full, drop newest value.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- data  in  NUM_CHANNELS*DATA_WIDTH  channel values; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- push_rdy  in  1  sink may accept a value this cycle (level).
- push_vld  out  1  one-cycle pulse: push_data/push_channel are valid.
- push_data  out  DATA_WIDTH  value being pushed.
- push_channel  out  CH_W  originating channel.
- overflow  out  NUM_CHANNELS  sticky per-channel flag: a value was coalesced or dropped.
- overflow_clr  in  NUM_CHANNELS  per-bit clear of overflow.

Behaviour:
- Reset (async assert, sync release):
  - push_vld=0, push_data=0, push_channel=0, overflow=0.
  - All FIFOs empty; prev[c]=0; init_pending[c]=1.
  - RR pointer = NUM_CHANNELS-1, so channel 0 has first priority.
- Reset mid-operation: queued entries are discarded; push_vld drops immediately.
- Initial snapshot: at the first posedge after rst deasserts, each channel enqueues data[c] unconditionally, then sets prev[c]=data[c] and clears init_pending[c].
- Change detect: at each posedge with init_pending[c]=0 and data[c] !== prev[c]:
  - enqueue data[c];
  - prev[c] <= data[c], updated even if the value is dropped.
- Full FIFO on an enqueue with no simultaneous pop from that channel:
  - COALESCE=1: youngest entry is overwritten; count unchanged; overflow[c] set.
  - COALESCE=0: value discarded; overflow[c] set.
- Full FIFO with a simultaneous pop on the same channel: enqueue accepted normally; no overflow.
- Empty FIFO with an enqueue: that entry is not poppable in the same cycle. Pop decisions use registered FIFO state only.
- Drain, per posedge:
  - If push_rdy=1 and any FIFO is non-empty, grant the first non-empty channel searching from RR+1, wrapping modulo NUM_CHANNELS.
  - Pop its head; next cycle push_vld=1, push_data=head, push_channel=c; RR <= c.
  - Otherwise push_vld<=0 and push_data/push_channel hold their values.
  - At most one pop per cycle.
- Latency: a change sampled at edge N gives push_vld high after edge N+1 at the earliest, if push_rdy=1 at edge N+1 and the channel wins arbitration.
- Ordering: within a channel, values leave in FIFO order. No ordering guarantee across channels beyond round-robin.
- overflow: overflow_clr[c] clears bit c. A set event in the same cycle as a clear wins (bit stays 1).
- FIFO pointers wrap modulo QUEUE_DEPTH; count width is $clog2(QUEUE_DEPTH+1).

Decomposition:
- Package multisim_quasi_static_pkg:
  - function ch_width(n) = max(1, $clog2(n)), giving CH_W;
  - typedef of the FIFO count type.
- Sub-module multisim_quasi_static_chan, one per channel via generate:
  - change detect, init snapshot, FIFO with coalesce/drop, overflow flag;
  - ports: pop, empty, head, overflow, overflow_clr.
- Top level holds the round-robin arbiter and output registers.

Test Plan:
- Snapshot: NUM_CHANNELS=4, data={4,3,2,1} held, push_rdy=1 after reset.
  - Expect four pushes on consecutive cycles: (ch0,1), (ch1,2), (ch2,3), (ch3,4). No further push_vld.
- Change order: push_rdy=0; ch1 changes 2→5→6→7 on consecutive cycles; then push_rdy=1.
  - Expect ch1 to emit 2,5,6,7 in that order; overflow[1]=0.
- Coalesce: COALESCE=1, QUEUE_DEPTH=2, push_rdy=0; ch2 changes 10→11→12→13.
  - FIFO ends holding {10,13} and overflow[2]=1.
  - With push_rdy=1, expect outputs 10 then 13.
  - Pulse overflow_clr[2] → overflow[2]=0.
- Drop: same stimulus with COALESCE=0.
  - Expect outputs 10, 11; overflow[2]=1.
  - Holding data=13 afterwards produces no re-enqueue.
- Fairness: all four channels change every cycle, push_rdy=1.
  - push_channel cycles 0,1,2,3,0,…; no channel is skipped while non-empty.
- Reset mid-drain: assert rst while ch0 has 3 entries and push_vld=1.
  - push_vld drops to 0 immediately.
  - After release, only the snapshot of the current data values is emitted.
